sys_ctrl_param: RTL



---
 rtl/sys_ctrl_param_if.sv | 44 ++++
 rtl/sys_ctrl_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_param_if.sv
// rtl/sys_ctrl_param_if.sv - bus bundle between the system controller and its UART/regfile/ALU/FIFO peers
interface sys_ctrl_param_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic [DATA_WIDTH-1:0]    REGFILE_RdData;
    logic                     REGFILE_RdData_VLD;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VLD;
    logic                     FIFO_FULL;
    logic                     REGFILE_WrEn;
    logic                     REGFILE_RdEn;
    logic [ADDR_WIDTH-1:0]    REGFILE_ADDRESS;
    logic [DATA_WIDTH-1:0]    REGFILE_WrData;
    logic                     ALU_EN;
    logic [FUN_WIDTH-1:0]     ALU_FUN;
    logic                     CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]    FIFO_P_DATA;
    logic                     FIFO_WR_INC;
    logic                     CMD_ERR;
    logic                     TIMEOUT_ERR;

    // Controller side
    modport master (
        input  RX_P_DATA, RX_D_VLD, REGFILE_RdData, REGFILE_RdData_VLD,
               ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        output REGFILE_WrEn, REGFILE_RdEn, REGFILE_ADDRESS, REGFILE_WrData,
               ALU_EN, ALU_FUN, CLK_GATE_EN, FIFO_P_DATA, FIFO_WR_INC,
               CMD_ERR, TIMEOUT_ERR
    );

    // Environment side (UART RX, regfile, ALU, TX FIFO)
    modport slave (
        output RX_P_DATA, RX_D_VLD, REGFILE_RdData, REGFILE_RdData_VLD,
               ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        input  REGFILE_WrEn, REGFILE_RdEn, REGFILE_ADDRESS, REGFILE_WrData,
               ALU_EN, ALU_FUN, CLK_GATE_EN, FIFO_P_DATA, FIFO_WR_INC,
               CMD_ERR, TIMEOUT_ERR
    );
endinterface

// File: rtl/sys_ctrl_param.sv
// rtl/sys_ctrl_param.sv - parametrised command-frame controller; optional stall timeout under SYS_CTRL_TIMEOUT_EN
module sys_ctrl_param #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    FUN_WIDTH      = 4,
    parameter int                    ALU_OUT_WIDTH  = 16,
    parameter int                    OPA_ADDR       = 0,
    parameter int                    OPB_ADDR       = 1,
    parameter logic [DATA_WIDTH-1:0] WR_CMD         = 'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD         = 'hBB,
    parameter logic [DATA_WIDTH-1:0] ALU_OP_CMD     = 'hCC,
    parameter logic [DATA_WIDTH-1:0] ALU_NOP_CMD    = 'hDD,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                 REF_CLK,
    input  logic                 rst_n,
    sys_ctrl_param_if.master     bus
);
    localparam int OUT_WORDS = (ALU_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int RES_W     = OUT_WORDS * DATA_WIDTH;
    localparam int CNT_W     = $clog2(OUT_WORDS + 1);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        OP_A, OP_B, ALU_FUNC, ALU_WAIT, TX_PUSH
    } state_t;

    state_t                  state_q;
    logic                    wr_en_q, rd_en_q, alu_en_q, gate_q, fifo_inc_q, cmd_err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q, fifo_data_q;
    logic [FUN_WIDTH-1:0]    alu_fun_q;
    logic [RES_W-1:0]        res_q;      // result, shifted down one word per push
    logic [CNT_W-1:0]        left_q;     // words still to push

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr_q;
    logic             tout_q;
    logic             counted_d, advance_d;

    // Which states are watched for stalls, and whether this cycle moves the frame forward
    always_comb begin
        counted_d = 1'b1;
        advance_d = bus.RX_D_VLD;
        case (state_q)
            IDLE, TX_PUSH: counted_d = 1'b0;
            RD_WAIT:       advance_d = bus.REGFILE_RdData_VLD;
            ALU_WAIT:      advance_d = bus.ALU_OUT_VLD;
            default:       advance_d = bus.RX_D_VLD;
        endcase
    end
`endif

    // Frame decoder FSM with registered strobes and result serialiser
    always_ff @(posedge REF_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            gate_q      <= 1'b0;
            fifo_inc_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            fifo_data_q <= '0;
            alu_fun_q   <= '0;
            res_q       <= '0;
            left_q      <= '0;
`ifdef SYS_CTRL_TIMEOUT_EN
            tmr_q       <= '0;
            tout_q      <= 1'b0;
`endif
        end else begin
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            fifo_inc_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == WR_CMD)           state_q <= WR_ADDR;
                    else if (bus.RX_P_DATA == RD_CMD)      state_q <= RD_ADDR;
                    else if (bus.RX_P_DATA == ALU_OP_CMD)  state_q <= OP_A;
                    else if (bus.RX_P_DATA == ALU_NOP_CMD) state_q <= ALU_FUNC;
                    else                                   cmd_err_q <= 1'b1;
                end
                WR_ADDR: if (bus.RX_D_VLD) begin
                    addr_q  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_q <= WR_DATA;
                end
                WR_DATA: if (bus.RX_D_VLD) begin
                    wr_data_q <= bus.RX_P_DATA;
                    wr_en_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                RD_ADDR: if (bus.RX_D_VLD) begin
                    addr_q  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_q <= 1'b1;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: if (bus.REGFILE_RdData_VLD) begin
                    res_q   <= RES_W'(bus.REGFILE_RdData);
                    left_q  <= CNT_W'(1);
                    state_q <= TX_PUSH;
                end
                OP_A: if (bus.RX_D_VLD) begin
                    addr_q    <= ADDR_WIDTH'(OPA_ADDR);
                    wr_data_q <= bus.RX_P_DATA;
                    wr_en_q   <= 1'b1;
                    state_q   <= OP_B;
                end
                OP_B: if (bus.RX_D_VLD) begin
                    addr_q    <= ADDR_WIDTH'(OPB_ADDR);
                    wr_data_q <= bus.RX_P_DATA;
                    wr_en_q   <= 1'b1;
                    state_q   <= ALU_FUNC;
                end
                ALU_FUNC: if (bus.RX_D_VLD) begin
                    alu_fun_q <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                    gate_q    <= 1'b1;
                    alu_en_q  <= 1'b1;
                    state_q   <= ALU_WAIT;
                end
                // Capture is taken even while the FIFO is full; the stall is in TX_PUSH
                ALU_WAIT: if (bus.ALU_OUT_VLD) begin
                    res_q   <= RES_W'(bus.ALU_OUT);
                    gate_q  <= 1'b0;
                    left_q  <= CNT_W'(OUT_WORDS);
                    state_q <= TX_PUSH;
                end
                TX_PUSH: if (!bus.FIFO_FULL) begin
                    fifo_data_q <= res_q[DATA_WIDTH-1:0];
                    fifo_inc_q  <= 1'b1;
                    res_q       <= res_q >> DATA_WIDTH;
                    left_q      <= left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef SYS_CTRL_TIMEOUT_EN
            // Stall watchdog: overrides the case above only when nothing advanced
            tout_q <= 1'b0;
            if (counted_d && !advance_d) begin
                if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    tmr_q   <= '0;
                    tout_q  <= 1'b1;
                    gate_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    tmr_q <= tmr_q + TMR_W'(1);
                end
            end else begin
                tmr_q <= '0;
            end
`endif
        end
    end

    assign bus.REGFILE_WrEn    = wr_en_q;
    assign bus.REGFILE_RdEn    = rd_en_q;
    assign bus.REGFILE_ADDRESS = addr_q;
    assign bus.REGFILE_WrData  = wr_data_q;
    assign bus.ALU_EN          = alu_en_q;
    assign bus.ALU_FUN         = alu_fun_q;
    assign bus.CLK_GATE_EN     = gate_q;
    assign bus.FIFO_P_DATA     = fifo_data_q;
    assign bus.FIFO_WR_INC     = fifo_inc_q;
    assign bus.CMD_ERR         = cmd_err_q;
`ifdef SYS_CTRL_TIMEOUT_EN
    assign bus.TIMEOUT_ERR     = tout_q;
`else
    assign bus.TIMEOUT_ERR     = 1'b0;
`endif
endmodule
